// File: rtl/mac8_signed_acc_if.sv
// Operand/result stream bundle for mac8_signed_acc: operand beats in, dot-product result out.
interface mac8_signed_acc_if #(
  parameter int unsigned ACC_W = 24
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_a;
  logic [7:0]       in_b;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic [3:0]       out_count;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_acc, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_acc, out_count, out_ovf
  );
endinterface

// File: rtl/mac8_signed_acc.sv
// Signed 8x8 multiply-accumulate producing one dot product per in_last/N_TERMS-bounded burst.
// Optional feature macro: MAC8_SATURATE_EN (saturating accumulator with sticky out_ovf).
module mac8_mul8x8_signed (
  input  logic [7:0]  a_i,
  input  logic [7:0]  b_i,
  output logic [15:0] p_o
);
  logic [15:0] a_ext;
  logic [15:0] sum;

  // Shift-add over b; the weight of b[7] is -128, so that row is subtracted.
  always_comb begin
    a_ext = {{8{a_i[7]}}, a_i};
    sum   = '0;
    for (int i = 0; i < 7; i++) begin
      if (b_i[i]) sum = sum + (a_ext << i);
    end
    if (b_i[7]) sum = sum - (a_ext << 7);
  end

  assign p_o = sum;
endmodule

module mac8_signed_acc #(
  parameter int unsigned N_TERMS = 8,
  parameter int unsigned ACC_W   = 24
) (
  input logic              clk,
  input logic              rst_n,
  mac8_signed_acc_if.slave bus
);
  typedef enum logic [1:0] {StIdle, StAcc, StDrain, StHold} state_e;

  state_e           state_q;
  logic [15:0]      prod_q;
  logic             prod_vld_q;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [3:0]       count_q;
  logic [15:0]      prod_w;
  logic             accept;
  logic             close;
  logic [ACC_W:0]   prod_ext;

  mac8_mul8x8_signed u_mul (
    .a_i (bus.in_a),
    .b_i (bus.in_b),
    .p_o (prod_w)
  );

  assign accept   = bus.in_valid && (state_q == StIdle || state_q == StAcc);
  assign close    = bus.in_last || (count_q == 4'(N_TERMS - 1));
  assign prod_ext = {{(ACC_W - 15){prod_q[15]}}, prod_q};

`ifdef MAC8_SATURATE_EN
  logic           ovf_q, ovf_d;
  logic [ACC_W:0] sum_w;

  // Once clamped, the accumulator is frozen until the result is consumed.
  always_comb begin
    sum_w = {acc_q[ACC_W-1], acc_q} + prod_ext;
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (!ovf_q) begin
      if (sum_w[ACC_W] != sum_w[ACC_W-1]) begin
        ovf_d = 1'b1;
        acc_d = sum_w[ACC_W] ? {1'b1, {(ACC_W - 1){1'b0}}} : {1'b0, {(ACC_W - 1){1'b1}}};
      end else begin
        acc_d = sum_w[ACC_W-1:0];
      end
    end
  end

  assign bus.out_ovf = rst_n & ovf_q;
`else
  always_comb begin
    acc_d = acc_q + prod_ext[ACC_W-1:0];
  end

  assign bus.out_ovf = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
      acc_q      <= '0;
      count_q    <= '0;
`ifdef MAC8_SATURATE_EN
      ovf_q      <= 1'b0;
`endif
    end else begin
      prod_vld_q <= 1'b0;
      if (prod_vld_q) begin
        acc_q <= acc_d;
`ifdef MAC8_SATURATE_EN
        ovf_q <= ovf_d;
`endif
      end
      unique case (state_q)
        StIdle, StAcc: begin
          if (accept) begin
            prod_q     <= prod_w;
            prod_vld_q <= 1'b1;
            count_q    <= count_q + 4'd1;
            state_q    <= close ? StDrain : StAcc;
          end
        end
        StDrain: state_q <= StHold;
        StHold: begin
          if (bus.out_ready) begin
            state_q <= StIdle;
            acc_q   <= '0;
            count_q <= '0;
`ifdef MAC8_SATURATE_EN
            ovf_q   <= 1'b0;
`endif
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Outputs are forced low combinationally so they read zero for the whole reset interval.
  assign bus.in_ready  = rst_n && (state_q == StIdle || state_q == StAcc);
  assign bus.out_valid = rst_n && (state_q == StHold);
  assign bus.out_acc   = rst_n ? acc_q : '0;
  assign bus.out_count = rst_n ? count_q : 4'd0;
endmodule

// File: tb/tb_mac8_signed_acc.sv
// Directed self-checking bench for mac8_signed_acc (24-bit default and a 16-bit instance).
module tb_mac8_signed_acc;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mac8_signed_acc_if #(.ACC_W(24)) m ();
  mac8_signed_acc_if #(.ACC_W(16)) s ();

  mac8_signed_acc #(.N_TERMS(8), .ACC_W(24)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (m.slave)
  );

  mac8_signed_acc #(.N_TERMS(8), .ACC_W(16)) u_dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (s.slave)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic signed [7:0] a, input logic signed [7:0] b,
                       input logic last);
    m.in_valid = v;
    m.in_a     = a;
    m.in_b     = b;
    m.in_last  = last;
  endtask

  logic signed [31:0] held_acc;

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 8'sd0, 8'sd0, 1'b0);
    m.out_ready = 1'b0;
    s.in_valid = 1'b0; s.in_a = '0; s.in_b = '0; s.in_last = 1'b0; s.out_ready = 1'b0;

    // Reset held for two cycles
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_in_ready", m.in_ready, 0);
      check("rst_out_valid", m.out_valid, 0);
      check("rst_out_acc", $signed(m.out_acc), 0);
      check("rst_out_count", m.out_count, 0);
      check("rst_out_ovf", m.out_ovf, 0);
    end
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", m.in_ready, 1);

    // Idle with no valid stays idle
    tick();
    tick();
    check("idle_in_ready", m.in_ready, 1);
    check("idle_out_valid", m.out_valid, 0);

    // Single term -128 x -128
    drive(1'b1, -8'sd128, -8'sd128, 1'b1);
    tick();
    drive(1'b0, 8'sd0, 8'sd0, 1'b0);
    check("single_t1_valid", m.out_valid, 0);
    check("single_t1_ready", m.in_ready, 0);
    tick();
    check("single_t2_valid", m.out_valid, 1);
    check("single_acc", $signed(m.out_acc), 16384);
    check("single_count", m.out_count, 1);
    m.out_ready = 1'b1;
    tick();
    m.out_ready = 1'b0;
    check("single_rel_valid", m.out_valid, 0);
    check("single_rel_ready", m.in_ready, 1);
    check("single_rel_acc", $signed(m.out_acc), 0);
    check("single_rel_count", m.out_count, 0);

    // Mixed signs: -63 - 300 + 1 = -362
    drive(1'b1, -8'sd7, 8'sd9, 1'b0);
    tick();
    drive(1'b1, 8'sd100, -8'sd3, 1'b0);
    tick();
    drive(1'b1, -8'sd1, -8'sd1, 1'b1);
    tick();
    drive(1'b0, 8'sd0, 8'sd0, 1'b0);
    tick();
    check("mixed_valid", m.out_valid, 1);
    check("mixed_acc", $signed(m.out_acc), -362);
    check("mixed_count", m.out_count, 3);
    m.out_ready = 1'b1;
    tick();
    m.out_ready = 1'b0;

    // Auto-close after N_TERMS beats of 3 x -5
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'sd3, -8'sd5, 1'b0);
      tick();
      if (i == 6) check("auto_ready_before_last", m.in_ready, 1);
    end
    drive(1'b0, 8'sd0, 8'sd0, 1'b0);
    check("auto_ready_after_8", m.in_ready, 0);
    tick();
    check("auto_valid", m.out_valid, 1);
    check("auto_acc", $signed(m.out_acc), -120);
    check("auto_count", m.out_count, 8);

    // Backpressure for five cycles
    held_acc = $signed(m.out_acc);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", m.out_valid, 1);
      check("bp_acc", $signed(m.out_acc), -120);
      check("bp_ready", m.in_ready, 0);
    end
    m.out_ready = 1'b1;
    tick();
    m.out_ready = 1'b0;
    check("bp_rel_valid", m.out_valid, 0);
    check("bp_rel_ready", m.in_ready, 1);

    // Reset mid-operation after three beats
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'sd1, 8'sd1, 1'b0);
      tick();
    end
    drive(1'b0, 8'sd0, 8'sd0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_ready", m.in_ready, 0);
    check("midrst_valid", m.out_valid, 0);
    check("midrst_acc", $signed(m.out_acc), 0);
    tick();
    rst_n = 1'b1;
    #1;
    check("midrst_post_ready", m.in_ready, 1);
    check("midrst_post_count", m.out_count, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("midrst_no_valid", m.out_valid, 0);
    end
    drive(1'b1, 8'sd2, 8'sd7, 1'b1);
    tick();
    drive(1'b0, 8'sd0, 8'sd0, 1'b0);
    tick();
    check("midrst_new_valid", m.out_valid, 1);
    check("midrst_new_acc", $signed(m.out_acc), 14);
    check("midrst_new_count", m.out_count, 1);
    m.out_ready = 1'b1;
    tick();
    m.out_ready = 1'b0;

    // 16-bit accumulator: three (-128)x(-128) terms
    for (int i = 0; i < 3; i++) begin
      s.in_valid = 1'b1; s.in_a = 8'h80; s.in_b = 8'h80; s.in_last = (i == 2);
      tick();
    end
    s.in_valid = 1'b0; s.in_last = 1'b0;
    tick();
    check("sat_valid", s.out_valid, 1);
    check("sat_count", s.out_count, 3);
`ifdef MAC8_SATURATE_EN
    check("sat_acc", $signed(s.out_acc), 32767);
    check("sat_ovf", s.out_ovf, 1);
`else
    check("wrap_acc", $signed(s.out_acc), -16384);
    check("wrap_ovf", s.out_ovf, 0);
`endif
    s.out_ready = 1'b1;
    tick();
    s.out_ready = 1'b0;
    check("sat_rel_ovf", s.out_ovf, 0);
    check("sat_rel_acc", $signed(s.out_acc), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mac8_signed_acc.md
MAC8_SIGNED_ACC -- requirements
Module: mac8_signed_acc

Interface
REQ-001 SHALL have parameter N_TERMS, default 8, giving the maximum terms per dot product (legal 1..15).
REQ-002 SHALL have parameter ACC_W, default 24, giving the accumulator width in bits (legal 16..32).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset is synchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1 bit: the operand pair is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts an operand pair.
REQ-007 SHALL have port in_a, input, 8 bits: two's-complement multiplicand.
REQ-008 SHALL have port in_b, input, 8 bits: two's-complement multiplier.
REQ-009 SHALL have port in_last, input, 1 bit: the beat closes the current dot product.
REQ-010 SHALL have port out_valid, output, 1 bit: the result is presented.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-012 SHALL have port out_acc, output, ACC_W bits: signed dot-product result.
REQ-013 SHALL have port out_count, output, 4 bits: number of terms accumulated.
REQ-014 SHALL have port out_ovf, output, 1 bit: sticky overflow flag for the result.

Function
REQ-015 SHALL form each 16-bit signed product by instantiating the team's combinational 8x8 signed multiplier, not by using the * operator.
REQ-016 SHALL implement states IDLE, ACC, DRAIN and HOLD.
REQ-017 SHALL drive in_ready=1 in IDLE and ACC, and 0 in DRAIN and HOLD.
REQ-018 SHALL accept a beat when in_valid and in_ready are both 1 on a rising edge.
REQ-019 SHALL leave state unchanged when in_valid=0.
REQ-020 SHALL register the product 1 cycle after acceptance.
REQ-021 SHALL add the sign-extended product into the accumulator 2 cycles after acceptance; the pipeline SHALL sustain 1 beat/cycle.
REQ-022 SHALL move from IDLE to ACC on the first accepted beat that does not close the dot product.
REQ-023 SHALL close the dot product on the accepted beat with in_last=1 or with count reaching N_TERMS, whichever comes first.
REQ-024 SHALL move to DRAIN on the closing beat, from IDLE or ACC.
REQ-025 SHALL move from DRAIN to HOLD after exactly 1 cycle.
REQ-026 SHALL assert out_valid only in HOLD, i.e. 2 cycles after the closing beat is accepted.
REQ-027 SHALL hold out_acc, out_count and out_ovf stable while out_valid=1 and out_ready=0.
REQ-028 SHALL move from HOLD to IDLE when out_ready=1, clearing the accumulator, count and ovf on that same edge.
REQ-029 SHALL make a new beat acceptable on the first cycle after the HOLD-to-IDLE transition; there is no bypass.
REQ-030 SHALL ignore out_ready outside HOLD.
REQ-031 SHALL increment out_count once per accepted beat; its value equals the number of terms in the result.

Reset
REQ-032 SHALL, while rst_n=0 at a rising edge, force state=IDLE, accumulator=0, count=0, ovf=0 and product register=0.
REQ-033 SHALL drive in_ready=0, out_valid=0, out_acc=0, out_count=0 and out_ovf=0 while rst_n=0.
REQ-034 SHALL discard any partial dot product or undelivered result on a mid-operation reset, with no output pulse.

Configuration
REQ-035 SHALL, with MAC8_SATURATE_EN defined, clamp the accumulator to +(2^(ACC_W-1)-1) or -2^(ACC_W-1) on signed overflow, keep it clamped for the rest of the dot product, and set out_ovf sticky.
REQ-036 SHALL, without MAC8_SATURATE_EN, wrap the accumulator modulo 2^ACC_W and tie out_ovf to constant 0.

Verification
REQ-037 SHALL check reset: rst_n=0 for 2 cycles -> all outputs 0; first cycle after release -> in_ready=1.
REQ-038 SHALL check a single term: a=-128, b=-128, in_last=1 accepted at cycle t -> out_valid at t+2, out_acc=16384, out_count=1.
REQ-039 SHALL check the auto-close: 8 beats of a=3, b=-5 with in_last=0 (N_TERMS=8) -> out_acc=-120, out_count=8, in_ready=0 after the 8th beat.
REQ-040 SHALL check backpressure: out_ready=0 for 5 cycles in HOLD -> out_valid=1 and out_acc stable throughout, in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-041 SHALL check saturation with ACC_W=16: 3 beats of (-128)x(-128) -> with MAC8_SATURATE_EN out_acc=32767, out_ovf=1; without it out_acc=-16384, out_ovf=0.
REQ-042 SHALL check reset mid-operation: rst_n=0 for 1 cycle after 3 beats -> no out_valid; then a=2, b=7, in_last=1 -> out_acc=14, out_count=1.
